period_meter: RTL

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/siggen_pkg.sv | 15 +
 rtl/period_meter_if.sv | 14 +
 rtl/edge_detect.sv | 20 ++
 rtl/period_meter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/siggen_pkg.sv
// Shared types and helpers for the period measurement block.
package siggen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    // Interval index needs at least one bit even when no averaging is configured.
    function automatic int idx_width(input int avg_log2);
        return (avg_log2 > 0) ? avg_log2 : 1;
    endfunction

endpackage

// File: rtl/period_meter_if.sv
// Signal bundle for the period meter: strobe/enable in, averaged period and status out.
interface period_meter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             tick;
    logic [WIDTH-1:0] period;
    logic             valid;
    logic             locked;
    logic             overflow;

    modport master (output en, tick, input period, valid, locked, overflow);
    modport slave  (input en, tick, output period, valid, locked, overflow);
endinterface

// File: rtl/edge_detect.sv
// Rising-edge detector; the delayed copy is cleared on reset so a level high
// right after reset reads as an edge.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);
    logic in_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    assign rise = in & ~in_q;
endmodule

// File: rtl/period_meter.sv
// Measures clk cycles between tick rising edges and reports the average over
// 2^AVG_LOG2 back-to-back intervals, with lock and sticky timeout status.
module period_meter
    import siggen_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int AVG_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             tick,
    output logic [WIDTH-1:0] period,
    output logic             valid,
    output logic             locked,
    output logic             overflow
);
    localparam int ACC_W = WIDTH + AVG_LOG2;
    localparam int IDX_W = idx_width(AVG_LOG2);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   period_q, period_d;
    logic               valid_q, valid_d;
    logic               locked_q, locked_d;
    logic               overflow_q, overflow_d;
    logic               tick_rise;
    logic [ACC_W-1:0]   acc_sum;

    edge_detect u_edge (
        .clk  (clk),
        .rst  (rst),
        .in   (tick),
        .rise (tick_rise)
    );

    // Accumulator plus the interval closing this cycle.
    assign acc_sum = acc_q + ACC_W'(cnt_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        locked_d   = locked_q;
        overflow_d = overflow_q;

        if (!en) begin
            state_d  = IDLE;
            locked_d = 1'b0;
            cnt_d    = '0;
            acc_d    = '0;
            idx_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ARM;
                end
                ARM: begin
                    if (tick_rise) begin
                        cnt_d   = WIDTH'(1);
                        acc_d   = '0;
                        idx_d   = '0;
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    // An edge at full count is still a legal interval.
                    if (tick_rise) begin
                        cnt_d = WIDTH'(1);
                        if (idx_q == IDX_LAST) begin
                            period_d   = WIDTH'(acc_sum >> AVG_LOG2);
                            valid_d    = 1'b1;
                            locked_d   = 1'b1;
                            overflow_d = 1'b0;
                            acc_d      = '0;
                            idx_d      = '0;
                        end else begin
                            acc_d = acc_sum;
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        overflow_d = 1'b1;
                        locked_d   = 1'b0;
                        cnt_d      = '0;
                        acc_d      = '0;
                        idx_d      = '0;
                        state_d    = ARM;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign period   = period_q;
    assign valid    = valid_q;
    assign locked   = locked_q;
    assign overflow = overflow_q;
endmodule
